// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory posted-write buffer.
package dmem_pkg;

    localparam int WORD_W        = 32;
    localparam int WADDR_W       = 30;
    localparam int DEFAULT_DEPTH = 4;

    // One buffered store: word address plus full 32-bit data.
    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [WORD_W-1:0]  data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Store-to-load forwarding lookup: finds the youngest valid buffered store
// whose word address matches the load.
module wbuf_fwd_match
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = 2
) (
    input  wbuf_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PTR_W-1:0]   tail,
    input  logic [WADDR_W-1:0] load_waddr,
    output logic               hit,
    output logic [WORD_W-1:0]  data
);

    logic [DEPTH-1:0] match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match[gi] = valid[gi] && (entries[gi].waddr == load_waddr);
    end

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later hits overwrite
    // earlier ones, so the youngest matching store wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match[tail - PTR_W'(k)]) begin
                hit  = 1'b1;
                data = entries[tail - PTR_W'(k)].data;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO between the core data port and data_memory, with
// load forwarding and a read-priority memory port mux.
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Address_Core,
    input  logic [31:0] WriteData_Core,
    input  logic        MemWrite_Core,
    input  logic        MemRead_Core,
    output logic [31:0] ReadData_Core,
    output logic        Stall,
    output logic        Empty,
    output logic [31:0] Address_DataMem,
    output logic [31:0] WriteData_DataMem,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadData_DataMem
);

    wbuf_entry_t        entry_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               full, empty;
    logic               push, drain;
    logic [DEPTH-1:0]   valid;
    logic               fwd_hit;
    logic [WORD_W-1:0]  fwd_data;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign Empty = empty;
    assign Stall = MemWrite_Core & full;

    // A core read owns the memory port, so draining only happens on cycles
    // without a load.
    always_comb begin
        push    = MemWrite_Core & ~full;
        drain   = ~MemRead_Core & ~empty;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) head_d = head_q + PTR_W'(1);
        if (push)  tail_d = tail_q + PTR_W'(1);
        case ({push, drain})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: validity is derived from the pointers.
    always_ff @(posedge Clock) begin
        if (push) begin
            entry_q[tail_q] <= '{waddr: Address_Core[31:2], data: WriteData_Core};
        end
    end

    // An entry is live when its distance from head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [PTR_W-1:0] age;
        assign age       = PTR_W'(gi) - head_q;
        assign valid[gi] = ({1'b0, age} < count_q);
    end

    wbuf_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries    (entry_q),
        .valid      (valid),
        .tail       (tail_q),
        .load_waddr (Address_Core[31:2]),
        .hit        (fwd_hit),
        .data       (fwd_data)
    );

    assign ReadData_Core = (MemRead_Core && fwd_hit) ? fwd_data : ReadData_DataMem;

    // Memory outputs are forced quiet while reset is held.
    always_comb begin
        MemRead           = 1'b0;
        MemWrite          = 1'b0;
        Address_DataMem   = '0;
        WriteData_DataMem = '0;
        if (Reset) begin
            if (MemRead_Core) begin
                MemRead         = 1'b1;
                Address_DataMem = Address_Core;
            end else if (!empty) begin
                MemWrite          = 1'b1;
                Address_DataMem   = {entry_q[head_q].waddr, 2'b00};
                WriteData_DataMem = entry_q[head_q].data;
            end
        end
    end

endmodule
